// File: rtl/spi_device_interface_pkg.sv
// Shared types for the SPI device interface.
//   spi_state_e : transfer state of the device (idle / selected).
package spi_device_interface_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_input_synchronizer.sv
// N-stage flop chain bringing one asynchronous pad into the clk domain.
//   clk, rst : fabric clock, asynchronous active-high reset
//   d        : asynchronous pad input
//   q        : synchronized output (last stage), presets to RESET_VAL
module spi_input_synchronizer #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_q <= {STAGES{RESET_VAL}};
    else     chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/spi_device_interface.sv
// SPI mode-0 target. SCK/CS_N/MOSI are oversampled in the clk domain;
// received bytes leave as single-cycle strobes, transmit bytes come from a
// one-entry holding register with a ready/valid handshake.
//   clk, rst                 : fabric clock, asynchronous active-high reset
//   spi_sck/cs_n/mosi        : SPI pads from the host
//   spi_miso, spi_miso_oe    : MISO data and tristate enable
//   rx_valid/data/first      : received byte strobe, byte, first-byte qualifier
//   rx_abort                 : CS_N rose mid-byte
//   cs_start, cs_end         : synchronized CS_N fall / rise strobes
//   tx_valid/data/ready      : transmit holding register handshake
//   tx_underrun              : byte boundary with empty holding register
module spi_device_interface
  import spi_device_interface_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_FILL   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  output logic       rx_abort,
  output logic       cs_start,
  output logic       cs_end,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_underrun
);

  logic sck_s, cs_n_s, mosi_s;

  spi_input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(spi_sck), .q(sck_s)
  );
  spi_input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_n_s)
  );
  spi_input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s)
  );

  spi_state_e state_q, state_d;
  logic       sck_prev_q, cs_n_prev_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       first_q, first_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_first_q, rx_first_d;
  logic       rx_abort_q, rx_abort_d;
  logic       cs_start_q, cs_start_d;
  logic       cs_end_q, cs_end_d;
  logic       underrun_q, underrun_d;
  logic       load_byte;

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_n_s & cs_n_prev_q;
  assign cs_rise  = cs_n_s & ~cs_n_prev_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    first_d     = first_q;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    rx_first_d  = 1'b0;
    rx_abort_d  = 1'b0;
    cs_start_d  = 1'b0;
    cs_end_d    = 1'b0;
    underrun_d  = 1'b0;
    load_byte   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          cs_start_d = 1'b1;
          bit_cnt_d  = '0;
          first_d    = 1'b1;
          load_byte  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // CS_N rise takes priority over any SCK edge seen in the same cycle.
        if (cs_rise) begin
          state_d    = ST_IDLE;
          cs_end_d   = 1'b1;
          rx_abort_d = (bit_cnt_q != 3'd0);
          bit_cnt_d  = '0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_valid_d = 1'b1;
            rx_data_d  = {rx_shift_q[6:0], mosi_s};
            rx_first_d = first_q;
            first_d    = 1'b0;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q == 3'd0) load_byte  = 1'b1;
          else                   tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_byte) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_FILL;
        underrun_d = 1'b1;
      end
    end

    // Write decision uses the pre-load fullness: a write coinciding with an
    // underrun load fills the register for the following byte.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sck_prev_q  <= 1'b0;
      cs_n_prev_q <= 1'b1;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      first_q     <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_first_q  <= 1'b0;
      rx_abort_q  <= 1'b0;
      cs_start_q  <= 1'b0;
      cs_end_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_prev_q  <= sck_s;
      cs_n_prev_q <= cs_n_s;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      first_q     <= first_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rx_first_q  <= rx_first_d;
      rx_abort_q  <= rx_abort_d;
      cs_start_q  <= cs_start_d;
      cs_end_q    <= cs_end_d;
      underrun_q  <= underrun_d;
    end
  end

  assign spi_miso_oe = (state_q == ST_ACTIVE);
  assign spi_miso    = (state_q == ST_ACTIVE) ? tx_shift_q[7] : 1'b0;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_first    = rx_first_q;
  assign rx_abort    = rx_abort_q;
  assign cs_start    = cs_start_q;
  assign cs_end      = cs_end_q;
  assign tx_ready    = ~hold_full_q;
  assign tx_underrun = underrun_q;

endmodule
